// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALU control codes, RV M-extension op codes, muldiv FSM states
// and XLEN-dependent helper constants.
package alu_pkg;

    localparam logic [3:0] ALUCTRL_ADD  = 4'b0000;
    localparam logic [3:0] ALUCTRL_SUB  = 4'b0001;
    localparam logic [3:0] ALUCTRL_AND  = 4'b0010;
    localparam logic [3:0] ALUCTRL_OR   = 4'b0011;
    localparam logic [3:0] ALUCTRL_XOR  = 4'b0100;
    localparam logic [3:0] ALUCTRL_SLL  = 4'b0101;
    localparam logic [3:0] ALUCTRL_SRL  = 4'b0110;
    localparam logic [3:0] ALUCTRL_SRA  = 4'b0111;
    localparam logic [3:0] ALUCTRL_SLT  = 4'b1000;
    localparam logic [3:0] ALUCTRL_SLTU = 4'b1001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [63:0] md_most_neg(input int xlen);
        return 64'd1 << (xlen - 1);
    endfunction

    function automatic logic [63:0] md_all_ones(input int xlen);
        return (xlen >= 64) ? {64{1'b1}} : ((64'd1 << xlen) - 64'd1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: shift-add multiply or restoring divide,
// operating on the shared 2*XLEN accumulator ({hi,lo} / {rem,quot}).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_sub;

    always_comb begin
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
        rem_sh  = acc_i[2*XLEN-1:XLEN-1];
        ge      = (rem_sh >= {1'b0, opb_i});
        // rem_sh < 2*divisor, so when ge the difference fits in XLEN bits
        rem_sub = rem_sh[XLEN-1:0] - opb_i;
        if (is_div_i)
            acc_o = {(ge ? rem_sub : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], ge};
        else
            acc_o = {sum, acc_i[XLEN-1:1]};
    end
endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake.
// Operates on magnitudes one bit per cycle and applies sign in a FIXUP cycle.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_BITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_BITS-1:0] op,
    input  logic [XLEN-1:0]    rdata1,
    input  logic [XLEN-1:0]    rdata2,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               div_by_zero
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(md_most_neg(XLEN));
    localparam logic [XLEN-1:0] ALL_ONES = XLEN'(md_all_ones(XLEN));

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              dbz_q, dbz_d;

    logic [2:0]        opc;
    logic              s1, s2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   lo_fix, hi_fix;

    assign opc = op[2:0];

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_q[2]),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        s1   = rdata1[XLEN-1] & (opc == MD_MULH || opc == MD_MULHSU || opc == MD_DIV || opc == MD_REM);
        s2   = rdata2[XLEN-1] & (opc == MD_MULH || opc == MD_DIV || opc == MD_REM);
        mag1 = s1 ? -rdata1 : rdata1;
        mag2 = s2 ? -rdata2 : rdata2;

        prod   = neg_q ? -acc_q : acc_q;
        lo_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        hi_fix = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (state_q)
            ST_IDLE: if (in_valid) begin
                op_d  = opc;
                dbz_d = 1'b0;
                if (opc[2] && rdata2 == '0) begin
                    result_d = opc[1] ? rdata1 : ALL_ONES;
                    dbz_d    = 1'b1;
                    state_d  = ST_DONE;
                end else if ((opc == MD_DIV || opc == MD_REM) && rdata1 == MOST_NEG && rdata2 == ALL_ONES) begin
                    result_d = opc[1] ? '0 : rdata1;
                    state_d  = ST_DONE;
                end else begin
                    // mul: multiplier in acc low half, multiplicand added to high half
                    acc_d   = {{XLEN{1'b0}}, (opc[2] ? mag1 : mag2)};
                    opb_d   = opc[2] ? mag2 : mag1;
                    neg_d   = (opc[2] && opc[1]) ? s1 : (s1 ^ s2);
                    cnt_d   = CW'(XLEN);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                case (op_q)
                    MD_MUL:             result_d = prod[XLEN-1:0];
                    MD_DIV, MD_DIVU:    result_d = lo_fix;
                    MD_REM, MD_REMU:    result_d = hi_fix;
                    default:            result_d = prod[2*XLEN-1:XLEN];
                endcase
                state_d = ST_DONE;
            end
            default: if (out_ready) state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            dbz_d    = dbz_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=32): directed cases, abort cases and
// randomized ops against a plain-arithmetic reference model.
module tb_alu_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] rdata1 = '0, rdata2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    alu_muldiv #(.XLEN(XLEN), .OP_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rdata1(rdata1), .rdata2(rdata2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, output logic dz);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        logic [63:0] p;
        int ia = $signed(a);
        int ib = $signed(b);
        dz = 1'b0;
        p  = '0;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) begin dz = 1'b1; return 32'hFFFF_FFFF; end
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) begin dz = 1'b1; return 32'hFFFF_FFFF; end
                return a / b;
            end
            3'd6: begin
                if (b == 0) begin dz = 1'b1; return a; end
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) begin dz = 1'b1; return a; end
                return a % b;
            end
        endcase
    endfunction

    // Issue one op at a negedge, track latency, hold out_ready low for `stall` cycles.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int stall, input bit chk_lat);
        logic [31:0] exp_r, held;
        logic        exp_dz;
        bit          special;
        int          lat;
        exp_r   = ref_res(o, a, b, exp_dz);
        special = o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; rdata1 = a; rdata2 = b;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin lat = n; break; end
        end
        if (chk_lat || lat == 0)
            chk({tag, ".latency"}, 64'(lat), special ? 64'd1 : 64'(XLEN + 2));
        chk({tag, ".result"}, 64'(result), 64'(exp_r));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dz));
        held = result;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, ".hold"}, {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, held});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".release"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    logic [31:0] pool [8];
    logic [31:0] ra, rb;

    initial begin
        pool = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2, 32'd7, 32'd100};

        #12;
        chk("reset", {30'd0, in_ready, out_valid, div_by_zero, result}, {30'd0, 3'b100, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 0, 1'b1);
        do_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
        do_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        do_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'd2,         0, 1'b1);
        do_op("mul0",    3'd0, 32'd0,         32'd12345,     0, 1'b1);
        do_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         0, 1'b1);
        do_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         0, 1'b1);
        do_op("divu",    3'd5, 32'd100,       32'd7,         0, 1'b1);
        do_op("remu",    3'd7, 32'd100,       32'd7,         0, 1'b1);
        do_op("div0",    3'd4, 32'd5,         32'd0,         0, 1'b1);
        do_op("remu0",   3'd7, 32'd5,         32'd0,         0, 1'b1);
        do_op("divovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        do_op("removf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        do_op("bp",      3'd5, 32'd1000,      32'd3,         5, 1'b1);

        // flush during CALC
        in_valid = 1'b1; op = 3'd0; rdata1 = 32'd9; rdata2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.idle", {62'd0, in_ready, out_valid}, 64'd2);
        begin
            int seen = 0;
            for (int k = 0; k < 40; k++) begin @(negedge clk); seen += int'(out_valid); end
            chk("flush.no_valid", 64'(seen), 64'd0);
        end
        do_op("postflush", 3'd4, 32'd77, 32'hFFFF_FFF5, 0, 1'b1);

        // flush beats accept in the same cycle
        in_valid = 1'b1; flush = 1'b1; op = 3'd5; rdata1 = 32'd1; rdata2 = 32'd0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush.drop", {62'd0, in_ready, out_valid}, 64'd2);

        // async reset mid-CALC
        in_valid = 1'b1; op = 3'd4; rdata1 = 32'd1234; rdata2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst.async", {30'd0, in_ready, out_valid, div_by_zero, result}, {30'd0, 3'b100, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("postrst", 3'd6, 32'd1234, 32'd5, 0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : 32'($urandom);
            if ($urandom_range(0, 5) == 0) rb = rb & 32'hFF;
            do_op("rand", 3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
